// File: rtl/dphy_cal_pkg.sv
// Shared definitions for the D-PHY per-lane delay calibration controller.
//   - FSM state encoding (legacy-compatible localparam constants)
//   - tap_w(): tap index width for a given number of delay taps
//   - CNT_W: width of the per-window sync/error counters (saturating)
package dphy_cal_pkg;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned ST_W  = 3;

    typedef logic [ST_W-1:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_SETTLE  = 3'd1;
    localparam state_t ST_OBSERVE = 3'd2;
    localparam state_t ST_EVAL    = 3'd3;
    localparam state_t ST_INC     = 3'd4;
    localparam state_t ST_RETURN  = 3'd5;
    localparam state_t ST_NEXT    = 3'd6;
    localparam state_t ST_DONE    = 3'd7;

    // Width of a tap index; never below one bit.
    function automatic int unsigned tap_w(input int unsigned taps);
        return (taps > 1) ? $clog2(taps) : 1;
    endfunction

endpackage

// File: rtl/dphy_cal_window.sv
// Run tracker for the delay sweep: follows the current run of good taps and
// keeps the longest closed run (earliest wins ties) plus its centre tap.
// Ports:
//   ref_clk_i, ref_srst_i : clock, asynchronous active-high reset
//   clear                 : forget current and best run (start of a lane)
//   tap_valid, tap_good   : one verdict for tap 'tap'
//   close                 : close any open run (after the last tap's verdict)
//   tap                   : tap index the verdict belongs to
//   best_start, best_len  : longest closed run so far
//   centre                : best_start + best_len/2 (floored)
module dphy_cal_window #(
    parameter int unsigned TAP_W = 5
) (
    input  logic             ref_clk_i,
    input  logic             ref_srst_i,
    input  logic             clear,
    input  logic             tap_valid,
    input  logic             tap_good,
    input  logic             close,
    input  logic [TAP_W-1:0] tap,
    output logic [TAP_W-1:0] best_start,
    output logic [TAP_W:0]   best_len,
    output logic [TAP_W-1:0] centre
);

    logic [TAP_W-1:0] run_start;
    logic [TAP_W:0]   run_len;
    logic [TAP_W-1:0] cand_start;
    logic [TAP_W:0]   cand_len;
    logic [TAP_W-1:0] cand_centre;
    logic             closing;

    // Run as it stands after applying this cycle's verdict.
    always_comb begin
        cand_start = run_start;
        cand_len   = run_len;
        if (tap_valid && tap_good) begin
            cand_len = run_len + (TAP_W+1)'(1);
            if (run_len == '0) begin
                cand_start = tap;
            end
        end
        closing     = close || (tap_valid && !tap_good);
        cand_centre = cand_start + cand_len[TAP_W:1];
    end

    // Strictly-longer replacement keeps the earliest run on ties.
    always_ff @(posedge ref_clk_i or posedge ref_srst_i) begin
        if (ref_srst_i) begin
            run_start  <= '0;
            run_len    <= '0;
            best_start <= '0;
            best_len   <= '0;
            centre     <= '0;
        end else if (clear) begin
            run_start  <= '0;
            run_len    <= '0;
            best_start <= '0;
            best_len   <= '0;
            centre     <= '0;
        end else if (closing) begin
            run_len <= '0;
            if (cand_len > best_len) begin
                best_start <= cand_start;
                best_len   <= cand_len;
                centre     <= cand_centre;
            end
        end else begin
            run_start <= cand_start;
            run_len   <= cand_len;
        end
    end

endmodule

// File: rtl/dphy_delay_cal.sv
// Automatic per-lane input-delay calibration for the CSI-2 D-PHY data lanes.
// Sweeps each lane's delay through all taps, scores each tap from sync/error
// pulses, then steps the tap back to the centre of the widest clean window.
// Ports:
//   ref_clk_i, ref_srst_i : clock, asynchronous active-high reset
//   start_i               : request calibration of all lanes (ignored when busy)
//   sync_det_i/sync_err_i : per-lane sync found / sync-ECC error pulses
//   btn_i                 : async manual step buttons (DPHY_DELAY_CAL_MANUAL_EN only)
//   inc_delay_o           : one-cycle increment pulse per lane
//   busy_o, done_o        : calibration running / end-of-calibration pulse
//   fail_o                : sticky per-lane "no window of MIN_WINDOW taps"
//   center_tap_o          : final tap per lane, lane 0 in the LSBs
// Build option: define DPHY_DELAY_CAL_MANUAL_EN to add the manual step buttons.
module dphy_delay_cal
    import dphy_cal_pkg::*;
#(
    parameter int unsigned  DATA_LANES     = 2,
    parameter int unsigned  TAPS           = 32,
    parameter int unsigned  SETTLE_CYCLES  = 16,
    parameter int unsigned  OBSERVE_CYCLES = 4096,
    parameter int unsigned  MIN_WINDOW     = 3,
    localparam int unsigned TAP_W          = tap_w(TAPS)
) (
    input  logic                        ref_clk_i,
    input  logic                        ref_srst_i,
    input  logic                        start_i,
`ifdef DPHY_DELAY_CAL_MANUAL_EN
    input  logic [DATA_LANES-1:0]       btn_i,
`endif
    input  logic [DATA_LANES-1:0]       sync_det_i,
    input  logic [DATA_LANES-1:0]       sync_err_i,
    output logic [DATA_LANES-1:0]       inc_delay_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic [DATA_LANES-1:0]       fail_o,
    output logic [DATA_LANES*TAP_W-1:0] center_tap_o
);

    localparam int unsigned LANE_W  = (DATA_LANES > 1) ? $clog2(DATA_LANES) : 1;
    localparam int unsigned CYC_MAX = (SETTLE_CYCLES > OBSERVE_CYCLES) ? SETTLE_CYCLES : OBSERVE_CYCLES;
    localparam int unsigned CYC_W   = $clog2(CYC_MAX + 1);

    state_t               state, state_n;
    logic [LANE_W-1:0]    lane;
    logic [TAP_W-1:0]     tap;
    logic [CYC_W-1:0]     cyc_cnt;
    logic [TAP_W:0]       pulse_cnt;
    logic [CNT_W-1:0]     sync_cnt, err_cnt;

    logic                 win_clear, win_valid, win_close;
    logic                 fsm_inc, wr_center;
    logic [TAP_W-1:0]     win_best_start, win_centre;
    logic [TAP_W:0]       win_best_len;

    logic [DATA_LANES-1:0] lane_sel_c;
    logic [DATA_LANES-1:0] man_inc_c;
    logic                  sync_hit_c, err_hit_c, tap_good_c, win_pass_c;
    logic [TAP_W-1:0]      ret_tap_c;
    logic [TAP_W:0]        ret_pulses_c;

    // One-hot of the lane under calibration; selects its sync/err pulses.
    always_comb begin
        lane_sel_c = '0;
        for (int unsigned l = 0; l < DATA_LANES; l++) begin
            if (lane == LANE_W'(l)) begin
                lane_sel_c[l] = 1'b1;
            end
        end
    end

    assign sync_hit_c   = |(sync_det_i & lane_sel_c);
    assign err_hit_c    = |(sync_err_i & lane_sel_c);
    assign tap_good_c   = (sync_cnt != '0) && (err_cnt == '0);
    assign win_pass_c   = (win_best_len >= (TAP_W+1)'(MIN_WINDOW));
    assign ret_tap_c    = win_pass_c ? win_centre : '0;
    // The first return pulse wraps TAPS-1 to 0, hence centre+1 pulses.
    assign ret_pulses_c = (TAP_W+1)'(ret_tap_c) + (TAP_W+1)'(1);

    // State register.
    always_ff @(posedge ref_clk_i or posedge ref_srst_i) begin
        if (ref_srst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and control strobes.
    always_comb begin
        state_n   = state;
        win_clear = 1'b0;
        win_valid = 1'b0;
        win_close = 1'b0;
        fsm_inc   = 1'b0;
        wr_center = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    win_clear = 1'b1;
                    state_n   = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cyc_cnt == CYC_W'(SETTLE_CYCLES - 1)) begin
                    state_n = ST_OBSERVE;
                end
            end
            ST_OBSERVE: begin
                if (cyc_cnt == CYC_W'(OBSERVE_CYCLES - 1)) begin
                    state_n = ST_EVAL;
                end
            end
            ST_EVAL: begin
                win_valid = 1'b1;
                if (tap == TAP_W'(TAPS - 1)) begin
                    win_close = 1'b1;
                    state_n   = ST_RETURN;
                end else begin
                    state_n = ST_INC;
                end
            end
            ST_INC: begin
                fsm_inc = 1'b1;
                state_n = ST_SETTLE;
            end
            ST_RETURN: begin
                // One pulse, then SETTLE_CYCLES quiet cycles, per step.
                if (cyc_cnt == '0) begin
                    fsm_inc = 1'b1;
                end
                if ((cyc_cnt == CYC_W'(SETTLE_CYCLES)) && (pulse_cnt == ret_pulses_c)) begin
                    wr_center = 1'b1;
                    state_n   = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (lane == LANE_W'(DATA_LANES - 1)) begin
                    state_n = ST_DONE;
                end else begin
                    win_clear = 1'b1;
                    state_n   = ST_SETTLE;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Sweep datapath and registered outputs.
    always_ff @(posedge ref_clk_i or posedge ref_srst_i) begin
        if (ref_srst_i) begin
            lane         <= '0;
            tap          <= '0;
            cyc_cnt      <= '0;
            pulse_cnt    <= '0;
            sync_cnt     <= '0;
            err_cnt      <= '0;
            inc_delay_o  <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            fail_o       <= '0;
            center_tap_o <= '0;
        end else begin
            if ((state_n != state) || (state == ST_IDLE)) begin
                cyc_cnt <= '0;
            end else if ((state == ST_RETURN) && (cyc_cnt == CYC_W'(SETTLE_CYCLES))) begin
                cyc_cnt <= '0;
            end else begin
                cyc_cnt <= cyc_cnt + CYC_W'(1);
            end

            if ((state == ST_IDLE) && start_i) begin
                lane   <= '0;
                tap    <= '0;
                fail_o <= '0;
            end
            if (state == ST_INC) begin
                tap <= tap + TAP_W'(1);
            end
            if ((state == ST_NEXT) && (state_n == ST_SETTLE)) begin
                lane <= lane + LANE_W'(1);
                tap  <= '0;
            end

            // Per-window counters; the closing OBSERVE cycle is not sampled.
            if (state == ST_SETTLE) begin
                sync_cnt <= '0;
                err_cnt  <= '0;
            end else if ((state == ST_OBSERVE) && (cyc_cnt != CYC_W'(OBSERVE_CYCLES - 1))) begin
                if (sync_hit_c && (sync_cnt != '1)) begin
                    sync_cnt <= sync_cnt + CNT_W'(1);
                end
                if (err_hit_c && (err_cnt != '1)) begin
                    err_cnt <= err_cnt + CNT_W'(1);
                end
            end

            if (state != ST_RETURN) begin
                pulse_cnt <= '0;
            end else if (fsm_inc) begin
                pulse_cnt <= pulse_cnt + (TAP_W+1)'(1);
            end

            if (wr_center) begin
                for (int unsigned l = 0; l < DATA_LANES; l++) begin
                    if (lane_sel_c[l]) begin
                        center_tap_o[l*TAP_W +: TAP_W] <= ret_tap_c;
                        fail_o[l]                      <= ~win_pass_c;
                    end
                end
            end

            inc_delay_o <= (fsm_inc ? lane_sel_c : '0) | man_inc_c;
            busy_o      <= (state_n != ST_IDLE) && (state_n != ST_DONE);
            done_o      <= (state_n == ST_DONE);
        end
    end

`ifdef DPHY_DELAY_CAL_MANUAL_EN
    logic [DATA_LANES-1:0] btn_s1, btn_s2, btn_s3;

    // Two-flop synchroniser plus an edge flop per button.
    always_ff @(posedge ref_clk_i or posedge ref_srst_i) begin
        if (ref_srst_i) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
            btn_s3 <= '0;
        end else begin
            btn_s1 <= btn_i;
            btn_s2 <= btn_s1;
            btn_s3 <= btn_s2;
        end
    end

    assign man_inc_c = (btn_s2 & ~btn_s3) & {DATA_LANES{~busy_o}};
`else
    assign man_inc_c = '0;
`endif

    // The best window's centre can never precede its start.
    always_ff @(posedge ref_clk_i) begin
        if (!ref_srst_i && (state == ST_RETURN)) begin
            assert (win_centre >= win_best_start);
        end
    end

    dphy_cal_window #(
        .TAP_W (TAP_W)
    ) u_window (
        .ref_clk_i  (ref_clk_i),
        .ref_srst_i (ref_srst_i),
        .clear      (win_clear),
        .tap_valid  (win_valid),
        .tap_good   (tap_good_c),
        .close      (win_close),
        .tap        (tap),
        .best_start (win_best_start),
        .best_len   (win_best_len),
        .centre     (win_centre)
    );

endmodule

// File: tb/tb_dphy_delay_cal.sv
// Directed bench for dphy_delay_cal: a small D-PHY lane model follows each
// lane's tap from the inc_delay_o pulses and emits syncs/errors per scene.
module tb_dphy_delay_cal;

    localparam int unsigned NL     = 2;
    localparam int unsigned TAPS   = 32;
    localparam int unsigned SETTLE = 16;
    localparam int unsigned OBS    = 64;
    localparam int unsigned MINW   = 3;
    localparam int unsigned TW     = 5;

    logic              ref_clk_i;
    logic              ref_srst_i;
    logic              start_i;
    logic [NL-1:0]     sync_det_i;
    logic [NL-1:0]     sync_err_i;
    logic [NL-1:0]     inc_delay_o;
    logic              busy_o;
    logic              done_o;
    logic [NL-1:0]     fail_o;
    logic [NL*TW-1:0]  center_tap_o;
`ifdef DPHY_DELAY_CAL_MANUAL_EN
    logic [NL-1:0]     btn_i;
`endif

    int errors;
    int checks;
    int cyc;
    int pulses [NL];
    int tap_m  [NL];
    int dwell  [NL];
    int lo0 [NL];
    int hi0 [NL];
    int lo1 [NL];
    int hi1 [NL];
    int err_tap;
    int done_cnt;
    int gap_viol;
    int multi_viol;
    int done_busy_viol;
    int last_pulse;

    dphy_delay_cal #(
        .DATA_LANES     (NL),
        .TAPS           (TAPS),
        .SETTLE_CYCLES  (SETTLE),
        .OBSERVE_CYCLES (OBS),
        .MIN_WINDOW     (MINW)
    ) dut (
        .ref_clk_i    (ref_clk_i),
        .ref_srst_i   (ref_srst_i),
        .start_i      (start_i),
`ifdef DPHY_DELAY_CAL_MANUAL_EN
        .btn_i        (btn_i),
`endif
        .sync_det_i   (sync_det_i),
        .sync_err_i   (sync_err_i),
        .inc_delay_o  (inc_delay_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .fail_o       (fail_o),
        .center_tap_o (center_tap_o)
    );

    initial begin
        ref_clk_i = 1'b0;
        forever #5 ref_clk_i = ~ref_clk_i;
    end

    function automatic bit is_good(input int l, input int t);
        return ((t >= lo0[l]) && (t <= hi0[l])) || ((t >= lo1[l]) && (t <= hi1[l]));
    endfunction

    // Lane model: tap tracking, pulse bookkeeping and sync/err generation.
    initial begin
        cyc = 0;
        last_pulse = -1000;
        for (int l = 0; l < NL; l++) begin
            tap_m[l] = 0; dwell[l] = 0; pulses[l] = 0;
        end
        forever begin
            @(negedge ref_clk_i);
            cyc++;
            if (ref_srst_i) begin
                for (int l = 0; l < NL; l++) begin
                    tap_m[l] = 0; dwell[l] = 0;
                end
                last_pulse = -1000;
            end else begin
                if (inc_delay_o != '0) begin
                    if ($countones(inc_delay_o) > 1) multi_viol++;
                    if (cyc - last_pulse < int'(SETTLE) + 1) gap_viol++;
                    last_pulse = cyc;
                end
                for (int l = 0; l < NL; l++) begin
                    dwell[l]++;
                    if (inc_delay_o[l]) begin
                        pulses[l]++;
                        tap_m[l] = (tap_m[l] + 1) % int'(TAPS);
                        dwell[l] = 0;
                    end
                end
                if (done_o) begin
                    done_cnt++;
                    if (busy_o) done_busy_viol++;
                end
            end
            for (int l = 0; l < NL; l++) begin
                sync_det_i[l] = is_good(l, tap_m[l]) && ((dwell[l] % 2) == 0);
                sync_err_i[l] = (l == 1) && (tap_m[l] == err_tap) && (dwell[l] == 40);
            end
        end
    end

    task automatic set_scene(input int a0, input int b0, input int a1, input int b1,
                             input int c0, input int d0, input int c1, input int d1,
                             input int et);
        lo0[0] = a0; hi0[0] = b0; lo1[0] = a1; hi1[0] = b1;
        lo0[1] = c0; hi0[1] = d0; lo1[1] = c1; hi1[1] = d1;
        err_tap = et;
    endtask

    task automatic do_reset();
        @(negedge ref_clk_i);
        ref_srst_i = 1'b1;
        repeat (2) @(negedge ref_clk_i);
        ref_srst_i = 1'b0;
        @(negedge ref_clk_i);
    endtask

    task automatic test_reset();
        #2;
        checks++; if (inc_delay_o !== 2'b00) begin errors++; $display("FAIL reset_inc: got %b want 00", inc_delay_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_o); end
        checks++; if (fail_o !== 2'b00) begin errors++; $display("FAIL reset_fail: got %b want 00", fail_o); end
        checks++; if (center_tap_o !== 10'd0) begin errors++; $display("FAIL reset_center: got %0d want 0", center_tap_o); end
        @(negedge ref_clk_i);
        ref_srst_i = 1'b0;
        repeat (5) @(negedge ref_clk_i);
        checks++; if ((busy_o !== 1'b0) || (inc_delay_o !== 2'b00)) begin
            errors++; $display("FAIL idle_quiet: got busy=%b inc=%b want 0/00", busy_o, inc_delay_o);
        end
    endtask

    // Full calibration; optional start_i pulse while busy must be ignored.
    task automatic run_cal(input string name, input logic [9:0] exp_center, input logic [1:0] exp_fail,
                           input int exp_p0, input int exp_p1, input bit mid_start);
        int n;
        pulses[0] = 0; pulses[1] = 0;
        done_cnt = 0; gap_viol = 0; multi_viol = 0; done_busy_viol = 0;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL %s busy_pre: got %b want 0", name, busy_o); end
        start_i = 1'b1;
        @(negedge ref_clk_i);
        start_i = 1'b0;
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL %s busy_rise: got %b want 1", name, busy_o); end
        n = 0;
        while ((done_cnt == 0) && (n < 20000)) begin
            @(negedge ref_clk_i);
            n++;
            if (mid_start && (n == 3000)) begin
                start_i = 1'b1;
                @(negedge ref_clk_i);
                start_i = 1'b0;
                n++;
            end
        end
        checks++; if (done_cnt == 0) begin errors++; $display("FAIL %s timeout: got no done_o after %0d cycles want done", name, n); end
        repeat (40) @(negedge ref_clk_i);
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL %s done_count: got %0d want 1", name, done_cnt); end
        checks++; if (done_busy_viol != 0) begin errors++; $display("FAIL %s busy_with_done: got %0d overlaps want 0", name, done_busy_viol); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL %s busy_end: got %b want 0", name, busy_o); end
        checks++; if (center_tap_o !== exp_center) begin
            errors++; $display("FAIL %s center: got {%0d,%0d} want {%0d,%0d}", name,
                               center_tap_o[9:5], center_tap_o[4:0], exp_center[9:5], exp_center[4:0]);
        end
        checks++; if (fail_o !== exp_fail) begin errors++; $display("FAIL %s fail: got %b want %b", name, fail_o, exp_fail); end
        checks++; if (pulses[0] != exp_p0) begin errors++; $display("FAIL %s pulses_l0: got %0d want %0d", name, pulses[0], exp_p0); end
        checks++; if (pulses[1] != exp_p1) begin errors++; $display("FAIL %s pulses_l1: got %0d want %0d", name, pulses[1], exp_p1); end
        checks++; if ((gap_viol != 0) || (multi_viol != 0)) begin
            errors++; $display("FAIL %s pulse_spacing: got gap=%0d multi=%0d want 0/0", name, gap_viol, multi_viol);
        end
    endtask

    // Lane 0 good 10..20 -> 15, lane 1 good 4..8 -> 6.
    task automatic test_main();
        do_reset();
        set_scene(10, 20, 99, -1, 4, 8, 99, -1, -1);
        run_cal("main", {5'd6, 5'd15}, 2'b00, 47, 38, 1'b0);
    endtask

    // Later longer window wins on lane 0; lane 1 window of 2 fails.
    task automatic test_window_fail();
        do_reset();
        set_scene(2, 4, 20, 24, 7, 8, 99, -1, -1);
        run_cal("longer_fail", {5'd0, 5'd22}, 2'b10, 54, 32, 1'b0);
    endtask

    // Tie keeps the earliest run; an error at tap 12 splits lane 1's run.
    task automatic test_tie_err_split();
        do_reset();
        set_scene(2, 5, 20, 23, 4, 20, 99, -1, 12);
        run_cal("tie_err", {5'd8, 5'd4}, 2'b00, 36, 40, 1'b0);
    endtask

    // Reset during lane 1's RETURN aborts; restart recalibrates from tap 0.
    task automatic test_reset_return();
        int n;
        do_reset();
        set_scene(10, 20, 99, -1, 4, 8, 99, -1, -1);
        pulses[0] = 0; pulses[1] = 0;
        start_i = 1'b1;
        @(negedge ref_clk_i);
        start_i = 1'b0;
        n = 0;
        while ((pulses[1] < 33) && (n < 12000)) begin
            @(negedge ref_clk_i);
            n++;
        end
        checks++; if (pulses[1] < 33) begin errors++; $display("FAIL rst_ret_reach: got %0d pulses want >=33", pulses[1]); end
        checks++; if (center_tap_o[4:0] !== 5'd15) begin errors++; $display("FAIL rst_ret_l0_written: got %0d want 15", center_tap_o[4:0]); end
        ref_srst_i = 1'b1;
        #1;
        checks++; if ((inc_delay_o !== 2'b00) || (busy_o !== 1'b0) || (done_o !== 1'b0) ||
                      (fail_o !== 2'b00) || (center_tap_o !== 10'd0)) begin
            errors++; $display("FAIL rst_ret_outputs: got inc=%b busy=%b done=%b fail=%b center=%0d want all 0",
                               inc_delay_o, busy_o, done_o, fail_o, center_tap_o);
        end
        @(negedge ref_clk_i);
        checks++; if ((busy_o !== 1'b0) || (center_tap_o !== 10'd0)) begin
            errors++; $display("FAIL rst_ret_hold: got busy=%b center=%0d want 0/0", busy_o, center_tap_o);
        end
        ref_srst_i = 1'b0;
        repeat (2) @(negedge ref_clk_i);
        run_cal("restart", {5'd6, 5'd15}, 2'b00, 47, 38, 1'b1);
    endtask

`ifdef DPHY_DELAY_CAL_MANUAL_EN
    // Idle press gives one pulse three cycles later; busy press gives none.
    task automatic test_manual();
        int cnt;
        int first;
        do_reset();
        set_scene(10, 20, 99, -1, 4, 8, 99, -1, -1);
        cnt = 0; first = -1;
        btn_i = 2'b10;
        for (int k = 1; k <= 15; k++) begin
            @(negedge ref_clk_i);
            if (inc_delay_o[1]) begin
                cnt++;
                if (first < 0) first = k;
            end
            if (k == 10) btn_i = 2'b00;
        end
        checks++; if (cnt != 1) begin errors++; $display("FAIL man_idle_count: got %0d want 1", cnt); end
        checks++; if (first != 3) begin errors++; $display("FAIL man_idle_latency: got %0d want 3", first); end
        start_i = 1'b1;
        @(negedge ref_clk_i);
        start_i = 1'b0;
        repeat (5) @(negedge ref_clk_i);
        cnt = 0;
        btn_i = 2'b10;
        for (int k = 1; k <= 15; k++) begin
            @(negedge ref_clk_i);
            if (inc_delay_o[1]) cnt++;
            if (k == 10) btn_i = 2'b00;
        end
        checks++; if (cnt != 0) begin errors++; $display("FAIL man_busy_count: got %0d want 0", cnt); end
        do_reset();
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        done_cnt = 0; gap_viol = 0; multi_viol = 0; done_busy_viol = 0;
        ref_srst_i = 1'b1;
        start_i = 1'b0;
        sync_det_i = '0;
        sync_err_i = '0;
`ifdef DPHY_DELAY_CAL_MANUAL_EN
        btn_i = '0;
`endif
        set_scene(99, -1, 99, -1, 99, -1, 99, -1, -1);
        test_reset();
        test_main();
        test_window_fail();
        test_tie_err_split();
        test_reset_return();
`ifdef DPHY_DELAY_CAL_MANUAL_EN
        test_manual();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
